// File: rtl/cam_capture.sv
// cam_capture: assembles two-byte RGB565 camera pixels into RGB332 (DW=8) or
// RGB565 (DW=16) frame-buffer writes with line-aware addressing and a per-frame
// start/stop FSM. Single clock domain (pclk), asynchronous active-low reset.
// Optional build macro CAM_DECIM_EN adds 2:1 decimation in both axes.
module cam_capture #(
   parameter int AW      = 15,
   parameter int DW      = 8,
   parameter int H_PIX   = 160,
   parameter int V_LINES = 120
) (
   input  logic          pclk,
   input  logic          rst,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    px_data,
   input  logic          cap_en,
   output logic [AW-1:0] mem_px_addr,
   output logic [DW-1:0] mem_px_data,
   output logic          px_wr,
   output logic          frame_done,
   output logic          busy,
   output logic          ovf
);

   // Only the bits of b0 that reach the output word are kept.
   localparam int HW = (DW == 16) ? 8 : 6;
   localparam logic [AW-1:0] H_LIM = AW'(H_PIX);
   localparam logic [AW-1:0] V_LIM = AW'(V_LINES);
   localparam logic [AW-1:0] ONE   = AW'(1);

   if (!(DW == 8 || DW == 16)) begin : g_bad_dw
      $error("cam_capture: DW must be 8 or 16");
   end
   if (longint'(H_PIX) * longint'(V_LINES) > (longint'(1) << AW)) begin : g_bad_geom
      $error("cam_capture: H_PIX*V_LINES exceeds 2^AW");
   end

   typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_ACT, CAPTURE} state_t;

   state_t        state, state_next;
   logic          phase;
   logic          href_q;
   logic [HW-1:0] b0_part;
   logic [HW-1:0] b0_part_d;
   logic [DW-1:0] pix_word;
   logic [AW-1:0] col, line, line_base;
   logic          keep;

   if (DW == 16) begin : g_rgb565
      assign b0_part_d = px_data;
      assign pix_word  = {b0_part, px_data};
   end else begin : g_rgb332
      assign b0_part_d = {px_data[7:5], px_data[2:0]};
      assign pix_word  = {b0_part, px_data[4:3]};
   end

`ifdef CAM_DECIM_EN
   logic [AW-1:0] in_col, in_line;
   assign keep = !in_col[0] && !in_line[0];
`else
   assign keep = 1'b1;
`endif

   // Frame FSM state register.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Frame FSM next-state: wait for a full vsync cycle before capturing.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (cap_en) state_next = WAIT_VS;
         WAIT_VS:  if (vsync)  state_next = WAIT_ACT;
         WAIT_ACT: if (!vsync) state_next = CAPTURE;
         CAPTURE:  if (vsync)  state_next = cap_en ? WAIT_ACT : IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Byte assembly, addressing, clipping and registered outputs.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         phase       <= 1'b0;
         href_q      <= 1'b0;
         b0_part     <= '0;
         col         <= '0;
         line        <= '0;
         line_base   <= '0;
         mem_px_addr <= '0;
         mem_px_data <= '0;
         px_wr       <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         ovf         <= 1'b0;
`ifdef CAM_DECIM_EN
         in_col      <= '0;
         in_line     <= '0;
`endif
      end else begin
         px_wr      <= 1'b0;
         frame_done <= 1'b0;
         busy       <= (state_next == WAIT_ACT) || (state_next == CAPTURE);
         if (state == WAIT_ACT && !vsync) begin
            phase     <= 1'b0;
            href_q    <= 1'b0;
            col       <= '0;
            line      <= '0;
            line_base <= '0;
            ovf       <= 1'b0;
`ifdef CAM_DECIM_EN
            in_col    <= '0;
            in_line   <= '0;
`endif
         end else if (state == CAPTURE) begin
            if (vsync) begin
               frame_done <= 1'b1;
               phase      <= 1'b0;
               href_q     <= 1'b0;
            end else begin
               href_q <= href;
               if (href) begin
                  if (!phase) begin
                     b0_part <= b0_part_d;
                     phase   <= 1'b1;
                  end else begin
                     phase <= 1'b0;
`ifdef CAM_DECIM_EN
                     in_col <= in_col + ONE;
`endif
                     if (keep) begin
                        if (col < H_LIM && line < V_LIM) begin
                           mem_px_addr <= line_base + col;
                           mem_px_data <= pix_word;
                           px_wr       <= 1'b1;
                           col         <= col + ONE;
                        end else begin
                           ovf <= 1'b1;
                        end
                     end
                  end
               end else begin
                  phase <= 1'b0;
`ifdef CAM_DECIM_EN
                  if (href_q && in_col != '0) begin
                     in_col  <= '0;
                     in_line <= in_line + ONE;
                     if (!in_line[0] && col != '0) begin
                        col       <= '0;
                        line      <= line + ONE;
                        line_base <= line_base + H_LIM;
                     end
                  end
`else
                  if (href_q && col != '0) begin
                     col       <= '0;
                     line      <= line + ONE;
                     line_base <= line_base + H_LIM;
                  end
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: scoreboard bench for cam_capture. Two instances (RGB332 and
// RGB565, 4x3 geometry) share the camera inputs; a 2x2 RGB565 instance is added
// when CAM_DECIM_EN is defined.
module tb_cam_capture;

   localparam int AW = 15;

   logic          pclk = 1'b0;
   logic          rst, vsync, href, cap_en;
   logic [7:0]    px_data;

   logic [AW-1:0] addr8, addr16;
   logic [7:0]    data8;
   logic [15:0]   data16;
   logic          wr8, wr16, fd8, fd16, busy8, busy16, ovf8, ovf16;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } exp_t;

   exp_t q8[$];
   exp_t q16[$];
   int   checks = 0;
   int   fails  = 0;
   int   wcnt8  = 0;
   int   wcnt16 = 0;

   always #5 pclk = ~pclk;

   cam_capture #(.AW(AW), .DW(8), .H_PIX(4), .V_LINES(3)) dut8 (
      .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
      .cap_en(cap_en), .mem_px_addr(addr8), .mem_px_data(data8), .px_wr(wr8),
      .frame_done(fd8), .busy(busy8), .ovf(ovf8));

   cam_capture #(.AW(AW), .DW(16), .H_PIX(4), .V_LINES(3)) dut16 (
      .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
      .cap_en(cap_en), .mem_px_addr(addr16), .mem_px_data(data16), .px_wr(wr16),
      .frame_done(fd16), .busy(busy16), .ovf(ovf16));

`ifdef CAM_DECIM_EN
   logic [AW-1:0] addrd;
   logic [15:0]   datad;
   logic          wrd, fdd, busyd, ovfd;
   exp_t          qd[$];
   int            wcntd = 0;

   cam_capture #(.AW(AW), .DW(16), .H_PIX(2), .V_LINES(2)) dutd (
      .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .px_data(px_data),
      .cap_en(cap_en), .mem_px_addr(addrd), .mem_px_data(datad), .px_wr(wrd),
      .frame_done(fdd), .busy(busyd), .ovf(ovfd));

   // Scoreboard for the decimating instance.
   always @(negedge pclk) begin : mon_d
      exp_t e;
      if (wrd === 1'b1) begin
         wcntd++;
         checks++;
         if (qd.size() == 0) begin
            fails++;
            $display("[TB] FAIL wrd_unexpected: got addr=%0d data=%h, required no write", addrd, datad);
         end else begin
            e = qd.pop_front();
            if (addrd !== e.addr || datad !== e.data) begin
               fails++;
               $display("[TB] FAIL wrd_pixel: got addr=%0d data=%h, required addr=%0d data=%h",
                        addrd, datad, e.addr, e.data);
            end
         end
      end
   end
`endif

   // Scoreboard for the RGB332 instance.
   always @(negedge pclk) begin : mon_8
      exp_t e;
      if (wr8 === 1'b1) begin
         wcnt8++;
         checks++;
         if (q8.size() == 0) begin
            fails++;
            $display("[TB] FAIL wr8_unexpected: got addr=%0d data=%h, required no write", addr8, data8);
         end else begin
            e = q8.pop_front();
            if (addr8 !== e.addr || data8 !== e.data[7:0]) begin
               fails++;
               $display("[TB] FAIL wr8_pixel: got addr=%0d data=%h, required addr=%0d data=%h",
                        addr8, data8, e.addr, e.data[7:0]);
            end
         end
      end
   end

   // Scoreboard for the RGB565 instance.
   always @(negedge pclk) begin : mon_16
      exp_t e;
      if (wr16 === 1'b1) begin
         wcnt16++;
         checks++;
         if (q16.size() == 0) begin
            fails++;
            $display("[TB] FAIL wr16_unexpected: got addr=%0d data=%h, required no write", addr16, data16);
         end else begin
            e = q16.pop_front();
            if (addr16 !== e.addr || data16 !== e.data) begin
               fails++;
               $display("[TB] FAIL wr16_pixel: got addr=%0d data=%h, required addr=%0d data=%h",
                        addr16, data16, e.addr, e.data);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      href    = 1'b1;
      px_data = b;
      @(negedge pclk);
   endtask

   task automatic line_gap(input int n);
      href    = 1'b0;
      px_data = 8'h00;
      repeat (n) @(negedge pclk);
   endtask

   // Sends one pixel; a non-negative address pushes the expected write.
   task automatic send_pixel(input logic [7:0] b0, input logic [7:0] b1,
                             input int a, input int ad);
      exp_t e;
      send_byte(b0);
      href    = 1'b1;
      px_data = b1;
      if (a >= 0) begin
         e.addr = AW'(a);
         e.data = {8'h00, b0[7:5], b0[2:0], b1[4:3]};
         q8.push_back(e);
         e.data = {b0, b1};
         q16.push_back(e);
      end
`ifdef CAM_DECIM_EN
      if (ad >= 0) begin
         e.addr = AW'(ad);
         e.data = {b0, b1};
         qd.push_back(e);
      end
`else
      if (ad >= 0) e.addr = '0;
`endif
      @(negedge pclk);
   endtask

   task automatic test_reset;
      int n8;
      rst = 1'b0; vsync = 1'b0; href = 1'b0; px_data = 8'h00; cap_en = 1'b0;
      cyc(2);
      checks++;
      if ({addr8, data8, wr8, fd8, busy8, ovf8} !== '0 ||
          {addr16, data16, wr16, fd16, busy16, ovf16} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got busy=%b/%b ovf=%b/%b wr=%b/%b, required all 0",
                  busy8, busy16, ovf8, ovf16, wr8, wr16);
      end
      rst = 1'b1;
      cyc(2);
      cap_en = 1'b1;
      cyc(1);
      vsync = 1'b1; cyc(3);
      vsync = 1'b0; cyc(2);
      checks++;
      if (busy8 !== 1'b1 || busy16 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_capture_busy: got %b/%b, required 1", busy8, busy16);
      end
      send_byte(8'hAA);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (busy8 !== 1'b0 || busy16 !== 1'b0 || wr8 !== 1'b0 || addr8 !== '0 || data16 !== '0) begin
         fails++;
         $display("[TB] FAIL reset_async: got busy=%b/%b wr=%b, required 0", busy8, busy16, wr8);
      end
      href = 1'b0;
      @(negedge pclk);
      rst = 1'b1;
      n8 = wcnt8;
      for (int i = 0; i < 3; i++) send_pixel(8'h12, 8'h34, -1, -1);
      line_gap(2);
      checks++;
      if (wcnt8 != n8 || busy8 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_no_write: got writes=%0d busy=%b, required 0 and 0", wcnt8 - n8, busy8);
      end
      vsync = 1'b1; cyc(3);
      checks++;
      if (busy8 !== 1'b1 || busy16 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_wait_act: got busy=%b/%b, required 1", busy8, busy16);
      end
   endtask

   task automatic test_geometry;
      int n8;
      exp_t e;
      n8 = wcnt8;
      vsync = 1'b0; cyc(2);
      for (int l = 0; l < 3; l++) begin
         for (int p = 0; p < 4; p++) begin
            if (l == 0 && p == 0) begin
               send_byte(8'hE5);
               px_data = 8'h1B;
               e.addr = '0; e.data = 16'h00F7; q8.push_back(e);
               e.data = 16'hE51B; q16.push_back(e);
               @(negedge pclk);
            end else begin
               send_pixel(8'($urandom), 8'($urandom), l * 4 + p, -1);
            end
         end
         line_gap(3);
      end
      vsync = 1'b1;
      @(negedge pclk);
      checks++;
      if (fd8 !== 1'b1 || fd16 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL geom_frame_done: got %b/%b, required 1", fd8, fd16);
      end
      @(negedge pclk);
      checks++;
      if (fd8 !== 1'b0 || fd16 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL geom_frame_done_width: got %b/%b, required 0", fd8, fd16);
      end
      checks++;
      if (wcnt8 - n8 != 12 || q8.size() != 0 || q16.size() != 0) begin
         fails++;
         $display("[TB] FAIL geom_count: got writes=%0d pending=%0d/%0d, required 12 0 0",
                  wcnt8 - n8, q8.size(), q16.size());
      end
      checks++;
      if (ovf8 !== 1'b0 || busy8 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL geom_ovf_busy: got ovf=%b busy=%b, required 0 1", ovf8, busy8);
      end
   endtask

   task automatic test_short_long;
      vsync = 1'b0; cyc(2);
      for (int p = 0; p < 2; p++) send_pixel(8'($urandom), 8'($urandom), p, -1);
      line_gap(2);
      checks++;
      if (ovf8 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL sl_ovf_early: got %b, required 0", ovf8);
      end
      for (int p = 0; p < 6; p++)
         send_pixel(8'($urandom), 8'($urandom), (p < 4) ? 4 + p : -1, -1);
      send_byte(8'h55);
      line_gap(2);
      checks++;
      if (ovf8 !== 1'b1 || ovf16 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL sl_ovf: got %b/%b, required 1", ovf8, ovf16);
      end
      send_pixel(8'h81, 8'h42, 8, -1);
      line_gap(2);
      checks++;
      if (q8.size() != 0 || q16.size() != 0) begin
         fails++;
         $display("[TB] FAIL sl_pending: got %0d/%0d, required 0", q8.size(), q16.size());
      end
      vsync = 1'b1;
      @(negedge pclk);
      checks++;
      if (fd8 !== 1'b1 || ovf8 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL sl_end: got fd=%b ovf=%b, required 1 1", fd8, ovf8);
      end
      cyc(2);
   endtask

   task automatic test_gating;
      int n8;
      vsync = 1'b0; cyc(2);
      checks++;
      if (ovf8 !== 1'b0 || ovf16 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL gate_ovf_clear: got %b/%b, required 0", ovf8, ovf16);
      end
      cyc(1);
      cap_en = 1'b0;
      send_pixel(8'hF0, 8'h0F, 0, -1);
      send_pixel(8'h3C, 8'hC3, 1, -1);
      line_gap(2);
      vsync = 1'b1;
      @(negedge pclk);
      checks++;
      if (fd8 !== 1'b1 || busy8 !== 1'b0 || busy16 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL gate_stop: got fd=%b busy=%b/%b, required 1 0 0", fd8, busy8, busy16);
      end
      cyc(2);
      vsync = 1'b0; cyc(2);
      n8 = wcnt8;
      for (int i = 0; i < 2; i++) send_pixel(8'($urandom), 8'($urandom), -1, -1);
      line_gap(2);
      checks++;
      if (wcnt8 != n8 || busy8 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL gate_idle: got writes=%0d busy=%b, required 0 0", wcnt8 - n8, busy8);
      end
      cap_en = 1'b1;
      for (int i = 0; i < 2; i++) send_pixel(8'($urandom), 8'($urandom), -1, -1);
      line_gap(2);
      checks++;
      if (wcnt8 != n8 || busy8 !== 1'b0) begin
         fails++;
         $display("[TB] FAIL gate_midframe: got writes=%0d busy=%b, required 0 0", wcnt8 - n8, busy8);
      end
      vsync = 1'b1; cyc(3);
      vsync = 1'b0; cyc(2);
      checks++;
      if (busy8 !== 1'b1) begin
         fails++;
         $display("[TB] FAIL gate_restart_busy: got %b, required 1", busy8);
      end
      send_pixel(8'hA5, 8'h5A, 0, -1);
      send_pixel(8'h69, 8'h96, 1, -1);
      line_gap(2);
      checks++;
      if (wcnt8 - n8 != 2 || q8.size() != 0 || q16.size() != 0) begin
         fails++;
         $display("[TB] FAIL gate_restart: got writes=%0d pending=%0d, required 2 0", wcnt8 - n8, q8.size());
      end
      vsync = 1'b1; cyc(2);
   endtask

`ifdef CAM_DECIM_EN
   task automatic test_decim;
      int keep;
      vsync = 1'b0; cyc(2);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            keep = ((r % 2) == 0 && (c % 2) == 0) ? 1 : 0;
            send_pixel(8'h00, 8'(r * 4 + c),
                       keep ? (r / 2) * 4 + (c / 2) : -1,
                       keep ? (r / 2) * 2 + (c / 2) : -1);
         end
         line_gap(2);
      end
      checks++;
      if (wcntd != 4 || qd.size() != 0 || ovfd !== 1'b0) begin
         fails++;
         $display("[TB] FAIL decim_count: got writes=%0d pending=%0d ovf=%b, required 4 0 0",
                  wcntd, qd.size(), ovfd);
      end
      vsync = 1'b1;
      @(negedge pclk);
      checks++;
      if (fdd !== 1'b1) begin
         fails++;
         $display("[TB] FAIL decim_frame_done: got %b, required 1", fdd);
      end
      cyc(2);
   endtask
`endif

   initial begin
      test_reset;
`ifdef CAM_DECIM_EN
      test_decim;
`else
      test_geometry;
      test_short_long;
      test_gating;
`endif
      cyc(2);
      checks++;
      if (q8.size() != 0 || q16.size() != 0) begin
         fails++;
         $display("[TB] FAIL final_pending: got %0d/%0d, required 0", q8.size(), q16.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
